io_bus_master: RTL and testbench
================================

# io_bus_master

Initiator side of the 8-bit parallel I/O bus used by the parallel input/output interfaces: it turns a single-cycle request from the core into a complete bus cycle on `s_`, `a0`, `ior_`/`iow_` and the bidirectional `d7_d0` lines. Setup, strobe and hold phases have programmable length. The block sits between the processor datapath and any bus slave decoded by `s_`/`a0`, and returns read data with a one-cycle completion pulse.

## Interface
- `SETUP_CYC`, default 1: cycles with `s_`/`a0`/write data valid before the strobe falls; range 1..15.
- `STROBE_CYC`, default 2: minimum cycles the `ior_`/`iow_` strobe is low; range 1..15.
- `HOLD_CYC`, default 1: cycles `s_`/`a0`/write data stay valid after the strobe rises; range 1..15.
- `clock  input  1  system clock; all state changes on the rising edge`
- `reset  input  1  synchronous, active-high reset`
- `req  input  1  start request; sampled only in IDLE`
- `wr  input  1  direction of the request: 1 = write (`iow_`), 0 = read (`ior_`)`
- `addr  input  1  register select; becomes `a0``
- `wdata  input  8  write data; captured at request acceptance`
- `rdata  output  8  read data; holds its value until the next read completes`
- `busy  output  1  high while a bus cycle is in progress`
- `done  output  1  one-cycle completion pulse`
- `s_  output  1  slave select, active low`
- `a0  output  1  address line`
- `ior_  output  1  read strobe, active low`
- `iow_  output  1  write strobe, active low`
- `d7_d0  inout  8  data bus; driven only during write cycles, high-Z otherwise`
- `rdy  input  1  slave ready for wait states; present only with `IO_BUS_WAIT_EN``

## Operation
- FSM states are IDLE, SETUP, STROBE, HOLD and DONE. All bus outputs are registered, so no strobe glitches occur.
- **IDLE**
  - If `req`=1 at a clock edge, latch `wr`, `addr` and `wdata`, load the counter with SETUP_CYC, and go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP**: `s_`=0 and `a0`=latched address. On a write, `d7_d0` is driven with the latched data. After SETUP_CYC cycles, go to STROBE.
- **STROBE**: `ior_`=0 (read) or `iow_`=0 (write) for STROBE_CYC cycles.
  - On a read, `rdata` is loaded from `d7_d0` at the edge that leaves STROBE.
  - Then go to HOLD.
- **HOLD**: both strobes are 1, `s_`=0, and on a write `d7_d0` is still driven. After HOLD_CYC cycles, go to DONE.
- **DONE**: `s_`=1, `d7_d0` is high-Z, `done`=1 for exactly one cycle. Next state is IDLE.
- `busy` = (state ≠ IDLE).
- `req` is ignored outside IDLE; there is no queueing. A request arriving while `busy`=1 is lost, and the core must wait for `done`.
- `ior_` and `iow_` are never low in the same cycle.
- `d7_d0` is never driven during a read cycle or in IDLE/DONE.
- The phase counter is 4 bits and loads N−1 on phase entry, so each phase lasts exactly N cycles.

## Timing
- **Reset values:**
  - `s_`=1, `ior_`=1, `iow_`=1, `a0`=0
  - `d7_d0`=Z
  - `busy`=0, `done`=0, `rdata`=8'h00
  - state IDLE
- **Reset mid-cycle:** at the next edge, all outputs take their reset values. The strobe rises and the bus is released in the same cycle. No `done` pulse is produced, and `rdata` is cleared.
- **Latency:** request accepted at edge E0. `busy` is high for SETUP_CYC+STROBE_CYC+HOLD_CYC+1 cycles. `done` is high in the last of those cycles. With the defaults this is 5 cycles, with `done` in cycle 5 after E0.
- **Back-to-back requests:** earliest re-acceptance is the edge ending the DONE cycle, if `req`=1 there. The minimum gap with `s_`=1 between cycles is 1 cycle.
- `rdata` changes only at the STROBE→HOLD edge of a read. It is valid no later than the `done` cycle.

## Configuration
- `IO_BUS_WAIT_EN` defined:
  - The `rdy` port exists.
  - At the end of the STROBE count, the FSM stays in STROBE while `rdy`=0, with the strobe still low.
  - It leaves at the first edge with `rdy`=1 and the count expired. A read samples `d7_d0` at that edge.
  - There is no timeout.
- Macro undefined: the `rdy` port is absent and the strobe length is exactly STROBE_CYC.

## Test plan
- **Reset:** reset with defaults.
  - Outputs at reset values, `d7_d0` high-Z.
  - Then `req`=1, `wr`=1, `addr`=1, `wdata`=8'hA5.
  - Expected: `s_`/`a0` active for cycles 1–4, `iow_`=0 in cycles 2–3, `d7_d0`=8'hA5 in cycles 1–4, `done` in cycle 5, `ior_` always 1.
- **Read:** slave drives 8'h3C on `d7_d0` during the strobe; `req`=1, `wr`=0, `addr`=0.
  - Expected: `ior_`=0 for 2 cycles, `rdata`=8'h3C by the `done` cycle, `d7_d0` never driven by the block.
- **Back-to-back and ignored requests:** `req` held high continuously.
  - Expected: cycles repeat every 5 clocks with exactly 1 idle cycle (`s_`=1) between them. A pulse on `req` mid-cycle is ignored, with no extra `done`.
- **Reset mid-strobe:** reset asserted during STROBE of a write.
  - Expected: next cycle `iow_`=1, `s_`=1, `d7_d0`=Z, `busy`=0, and no `done`.
- **Parameters:** SETUP_CYC=3, STROBE_CYC=4, HOLD_CYC=2, read.
  - Expected: `busy` for 10 cycles, `ior_` low in cycles 4–7, `done` in cycle 10.
- **Wait states:** with `IO_BUS_WAIT_EN` and `rdy`=0 for 3 extra cycles, then 1.
  - Expected: strobe low for 5 cycles and data sampled at the `rdy`=1 edge. With `rdy` tied to 1, timing is identical to the macro-off build.

Source files
------------

// File: rtl/io_bus_master_if.sv
// ---------------------------------------------------------------------------
// io_bus_master_if
//
// Bundles the core-side request/response handshake and the control lines
// of the 8-bit parallel I/O bus that io_bus_master drives.
//
// Core side:
//   req    start request, looked at only when the master is free
//   wr     request direction, 1 = write (iow_), 0 = read (ior_)
//   addr   register select, presented on a0
//   wdata  write data, captured when the request is accepted
//   rdata  read data, held until the next read completes
//   busy   high while a bus cycle is in progress
//   done   one-cycle completion pulse
//
// Bus side:
//   s_     slave select, active low
//   a0     address line
//   ior_   read strobe, active low
//   iow_   write strobe, active low
//
// The bidirectional data lines d7_d0 are a separate inout port on the master.
// Tri-state nets resolve more predictably as plain module ports than as
// interface members.
// ---------------------------------------------------------------------------
interface io_bus_master_if;

    logic       req;
    logic       wr;
    logic       addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       s_;
    logic       a0;
    logic       ior_;
    logic       iow_;

    // The initiator receives core requests and drives the bus control lines.
    modport master (
        input  req,
        input  wr,
        input  addr,
        input  wdata,
        output rdata,
        output busy,
        output done,
        output s_,
        output a0,
        output ior_,
        output iow_
    );

    // The mirror view is for whoever issues requests and watches the bus.
    modport slave (
        output req,
        output wr,
        output addr,
        output wdata,
        input  rdata,
        input  busy,
        input  done,
        input  s_,
        input  a0,
        input  ior_,
        input  iow_
    );

endinterface

// File: rtl/io_bus_master.sv
// ---------------------------------------------------------------------------
// io_bus_master
//
// Initiator for the 8-bit parallel I/O bus. It turns a one-cycle request
// from the core into a complete bus cycle with four phases:
//   setup  : s_ low, a0 and any write data valid
//   strobe : ior_ or iow_ low
//   hold   : s_, a0 and any write data still valid
//   done   : bus released, one-cycle done pulse
// The setup, strobe and hold phases have programmable lengths.
//
// Parameters:
//   SETUP_CYC   cycles of setup before the strobe falls   (1..15)
//   STROBE_CYC  minimum cycles the strobe stays low        (1..15)
//   HOLD_CYC    cycles of hold after the strobe rises      (1..15)
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high reset
//   bus     io_bus_master_if.master: req/wr/addr/wdata in,
//           rdata/busy/done/s_/a0/ior_/iow_ out
//   d7_d0   bidirectional data bus. Driven only during write cycles.
//   rdy     slave ready for wait states. Present only when
//           IO_BUS_WAIT_EN is defined.
//
// Optional feature macro: IO_BUS_WAIT_EN
//   When it is defined, the strobe phase is stretched past STROBE_CYC while
//   rdy is low. When it is undefined, the strobe lasts exactly STROBE_CYC.
// ---------------------------------------------------------------------------
module io_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic            clock,
    input  logic            reset,
    io_bus_master_if.master bus,
    inout  wire  [7:0]      d7_d0
`ifdef IO_BUS_WAIT_EN
    ,
    input  logic            rdy
`endif
);

    // Each phase counter loads N-1 on entry. It then counts down to zero, so
    // a phase lasts exactly N cycles.
    localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        DONE
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [3:0] r_count;
    logic [3:0] w_nextCount;

    // Request fields captured at acceptance
    logic       r_wr;
    logic       r_addr;
    logic [7:0] r_wdata;
    logic [7:0] r_rdata;

    // Registered bus and status outputs
    logic       r_s;
    logic       r_a0;
    logic       r_ior;
    logic       r_iow;
    logic       r_drive;
    logic       r_busy;
    logic       r_done;

    // Combinational values for the next cycle
    logic       w_latch;
    logic       w_sample;
    logic       w_nextWr;
    logic       w_nextAddr;
    logic       w_nextActive;
    logic       w_nextS;
    logic       w_nextIor;
    logic       w_nextIow;
    logic       w_nextDrive;
    logic       w_nextBusy;
    logic       w_nextDone;
    logic       w_rdy;

`ifdef IO_BUS_WAIT_EN
    assign w_rdy = rdy;
`else
    assign w_rdy = 1'b1;
`endif

    // Next-state logic. DONE also accepts a request. This lets a core that
    // holds req high start a new cycle right after the done pulse, with the
    // DONE cycle as the single s_-high gap between bus cycles. Requests seen
    // in SETUP, STROBE or HOLD are dropped.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_latch     = 1'b0;
        w_sample    = 1'b0;

        case (r_state)
            IDLE: begin
                if (bus.req) begin
                    w_latch     = 1'b1;
                    w_nextState = SETUP;
                    w_nextCount = SETUP_LOAD;
                end
            end

            SETUP: begin
                if (r_count == 4'd0) begin
                    w_nextState = STROBE;
                    w_nextCount = STROBE_LOAD;
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end

            STROBE: begin
                // When the count has expired, the strobe ends only once the
                // slave is ready. A read samples the data bus on that same
                // edge.
                if (r_count == 4'd0) begin
                    if (w_rdy) begin
                        w_sample    = ~r_wr;
                        w_nextState = HOLD;
                        w_nextCount = HOLD_LOAD;
                    end
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end

            HOLD: begin
                if (r_count == 4'd0) begin
                    w_nextState = DONE;
                    w_nextCount = 4'd0;
                end else begin
                    w_nextCount = r_count - 4'd1;
                end
            end

            DONE: begin
                if (bus.req) begin
                    w_latch     = 1'b1;
                    w_nextState = SETUP;
                    w_nextCount = SETUP_LOAD;
                end else begin
                    w_nextState = IDLE;
                end
            end

            default: begin
                w_nextState = IDLE;
                w_nextCount = 4'd0;
            end
        endcase
    end

    // Output decode for the state being entered. The decoded values are
    // registered together with the state, so the strobes and the data-bus
    // enable come straight from flops and cannot glitch. Keeping ior_ and
    // iow_ tied to opposite values of the direction bit means both can never
    // be low at the same time.
    always_comb begin
        w_nextWr     = w_latch ? bus.wr   : r_wr;
        w_nextAddr   = w_latch ? bus.addr : r_addr;
        w_nextActive = (w_nextState == SETUP) ||
                       (w_nextState == STROBE) ||
                       (w_nextState == HOLD);
        w_nextS      = ~w_nextActive;
        w_nextIor    = ~((w_nextState == STROBE) && !w_nextWr);
        w_nextIow    = ~((w_nextState == STROBE) &&  w_nextWr);
        w_nextDrive  = w_nextActive && w_nextWr;
        w_nextBusy   = (w_nextState != IDLE);
        w_nextDone   = (w_nextState == DONE);
    end

    // State, counter, captured request and registered outputs. Reset returns
    // every output to its idle value on the next edge. This raises any active
    // strobe and releases the data bus without a done pulse, and it also
    // clears the read data.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= 4'd0;
            r_wr    <= 1'b0;
            r_addr  <= 1'b0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
            r_s     <= 1'b1;
            r_a0    <= 1'b0;
            r_ior   <= 1'b1;
            r_iow   <= 1'b1;
            r_drive <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            r_wr    <= w_nextWr;
            r_addr  <= w_nextAddr;
            if (w_latch) begin
                r_wdata <= bus.wdata;
            end
            if (w_sample) begin
                r_rdata <= d7_d0;
            end
            r_s     <= w_nextS;
            r_a0    <= w_nextAddr;
            r_ior   <= w_nextIor;
            r_iow   <= w_nextIow;
            r_drive <= w_nextDrive;
            r_busy  <= w_nextBusy;
            r_done  <= w_nextDone;
        end
    end

    // The data lines carry the captured write data only while a write cycle
    // owns the bus. At all other times they are left floating for the slave.
    assign d7_d0     = r_drive ? r_wdata : 8'hzz;

    assign bus.rdata = r_rdata;
    assign bus.busy  = r_busy;
    assign bus.done  = r_done;
    assign bus.s_    = r_s;
    assign bus.a0    = r_a0;
    assign bus.ior_  = r_ior;
    assign bus.iow_  = r_iow;

endmodule

// File: tb/tb_io_bus_master.sv
// ---------------------------------------------------------------------------
// tb_io_bus_master
//
// Drives two masters with identical core-side stimulus:
//   dut0  default timing (1/2/1)
//   dut1  3/4/2 timing
// Each data bus has pull-ups, so a released bus reads back as 8'hFF. A
// simple slave drives sData whenever the read strobe of its master is low.
// ---------------------------------------------------------------------------
module tb_io_bus_master;

    localparam logic I1 = 1'b1;
    localparam logic I0 = 1'b0;

    logic clock = 1'b0;
    logic reset;
    logic [7:0] sData;

    always #5 clock = ~clock;

    io_bus_master_if ifc0 ();
    io_bus_master_if ifc1 ();

    wire [7:0] dBus0;
    wire [7:0] dBus1;

    // Responsive slaves: they drive the data bus only while their read strobe
    // is low.
    assign dBus0 = (ifc0.ior_ == 1'b0) ? sData : 8'hzz;
    assign dBus1 = (ifc1.ior_ == 1'b0) ? sData : 8'hzz;

    for (genvar i = 0; i < 8; i++) begin : gPull
        pullup (dBus0[i]);
        pullup (dBus1[i]);
    end

`ifdef IO_BUS_WAIT_EN
    logic rdy0;
    logic rdy1;
`endif

    io_bus_master dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc0.master),
        .d7_d0 (dBus0)
`ifdef IO_BUS_WAIT_EN
        ,
        .rdy   (rdy0)
`endif
    );

    io_bus_master #(
        .SETUP_CYC  (3),
        .STROBE_CYC (4),
        .HOLD_CYC   (2)
    ) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (ifc1.master),
        .d7_d0 (dBus1)
`ifdef IO_BUS_WAIT_EN
        ,
        .rdy   (rdy1)
`endif
    );

    int assertions = 0;
    int failures   = 0;

    // One table row gives the inputs applied before an edge and the outputs
    // expected after that edge.
    typedef struct {
        logic       rst;
        logic       req;
        logic       wr;
        logic       addr;
        logic [7:0] wdata;
        logic       eS;
        logic       eA0;
        logic       chkA0;
        logic       eIor;
        logic       eIow;
        logic       eBusy;
        logic       eDone;
        logic [7:0] eRdata;
        logic [7:0] eBus;
    } vec_t;

    vec_t vecs[30];

    // Transaction-level reference model. pos counts the cycles since a
    // request was accepted (0 = idle). extra counts the wait cycles added to
    // the strobe phase.
    int         mS[2] = '{1, 3};
    int         mT[2] = '{2, 4};
    int         mH[2] = '{1, 2};
    int         mPos[2];
    int         mExtra[2];
    logic       mWr[2];
    logic [7:0] mWdata[2];
    logic       mAddr[2];
    logic [7:0] mRdata[2];

    logic       rRst;
    logic       rReq;
    logic       rWr;
    logic       rAddr;
    logic [7:0] rWdata;
    logic       rIn0;
    logic       rIn1;

    function automatic vec_t mkVec(
        input logic rst, input logic req, input logic wr, input logic addr,
        input logic [7:0] wdata, input logic eS, input logic eA0,
        input logic chkA0, input logic eIor, input logic eIow,
        input logic eBusy, input logic eDone, input logic [7:0] eRdata,
        input logic [7:0] eBus);
        vec_t v;
        v.rst = rst;   v.req = req;     v.wr = wr;       v.addr = addr;
        v.wdata = wdata;
        v.eS = eS;     v.eA0 = eA0;     v.chkA0 = chkA0;
        v.eIor = eIor; v.eIow = eIow;   v.eBusy = eBusy; v.eDone = eDone;
        v.eRdata = eRdata; v.eBus = eBus;
        return v;
    endfunction

    task automatic applyStimulus(input logic rst, input logic req,
                                 input logic wr, input logic addr,
                                 input logic [7:0] wdata);
        reset      = rst;
        ifc0.req   = req;  ifc1.req   = req;
        ifc0.wr    = wr;   ifc1.wr    = wr;
        ifc0.addr  = addr; ifc1.addr  = addr;
        ifc0.wdata = wdata; ifc1.wdata = wdata;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] actual,
                               input logic [7:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %02h, expected %02h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual,
                            input logic expected);
        checkOutput(name, {7'd0, actual}, {7'd0, expected});
    endtask

    // Advance the model for one edge, using the inputs present before that
    // edge.
    task automatic modelStep(input int d, input logic rst, input logic rq,
                             input logic w, input logic a,
                             input logic [7:0] wd, input logic ry,
                             input logic [7:0] sd);
        int se;
        int total;
        se    = mS[d] + mT[d] + mExtra[d];
        total = se + mH[d] + 1;
        if (rst) begin
            mPos[d]   = 0;
            mExtra[d] = 0;
            mRdata[d] = 8'h00;
            mAddr[d]  = 1'b0;
        end else if (mPos[d] == 0 || mPos[d] == total) begin
            if (rq) begin
                mPos[d]   = 1;
                mExtra[d] = 0;
                mWr[d]    = w;
                mAddr[d]  = a;
                mWdata[d] = wd;
            end else begin
                mPos[d] = 0;
            end
        end else if (mPos[d] == se) begin
            if (ry) begin
                if (!mWr[d]) mRdata[d] = sd;
            end else begin
                mExtra[d] = mExtra[d] + 1;
            end
            mPos[d] = mPos[d] + 1;
        end else begin
            mPos[d] = mPos[d] + 1;
        end
    endtask

    task automatic checkModel(input int d, input logic aS, input logic aA0,
                              input logic aIor, input logic aIow,
                              input logic aBusy, input logic aDone,
                              input logic [7:0] aRdata, input logic [7:0] aBus);
        int se;
        int total;
        logic active;
        logic strobing;
        logic [7:0] eBus;
        se       = mS[d] + mT[d] + mExtra[d];
        total    = se + mH[d] + 1;
        active   = (mPos[d] >= 1) && (mPos[d] <= se + mH[d]);
        strobing = (mPos[d] > mS[d]) && (mPos[d] <= se);
        if (active && mWr[d])        eBus = mWdata[d];
        else if (strobing && !mWr[d]) eBus = sData;
        else                          eBus = 8'hFF;
        checkBit($sformatf("rnd%0d s_", d), aS, !active);
        checkBit($sformatf("rnd%0d ior_", d), aIor, !(strobing && !mWr[d]));
        checkBit($sformatf("rnd%0d iow_", d), aIow, !(strobing && mWr[d]));
        checkBit($sformatf("rnd%0d busy", d), aBusy, mPos[d] != 0);
        checkBit($sformatf("rnd%0d done", d), aDone, mPos[d] == total);
        checkOutput($sformatf("rnd%0d rdata", d), aRdata, mRdata[d]);
        checkOutput($sformatf("rnd%0d bus", d), aBus, eBus);
        if (active) checkBit($sformatf("rnd%0d a0", d), aA0, mAddr[d]);
    endtask

    initial begin
        sData = 8'h3C;
`ifdef IO_BUS_WAIT_EN
        rdy0 = 1'b1;
        rdy1 = 1'b1;
`endif
        applyStimulus(I1, I0, I0, I0, 8'h00);

        // Reset, default write, read, reset in mid-strobe, and back-to-back
        // requests with requests made in mid-cycle ignored
        vecs[0]  = mkVec(I1,I0,I0,I0,8'h00, I1,I0,I1, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[1]  = mkVec(I0,I1,I1,I1,8'hA5, I0,I1,I1, I1,I1,I1,I0, 8'h00,8'hA5);
        vecs[2]  = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I0,I1,I0, 8'h00,8'hA5);
        vecs[3]  = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I0,I1,I0, 8'h00,8'hA5);
        vecs[4]  = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I1,I1,I0, 8'h00,8'hA5);
        vecs[5]  = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I1,I1, 8'h00,8'hFF);
        vecs[6]  = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[7]  = mkVec(I0,I1,I0,I0,8'h00, I0,I0,I1, I1,I1,I1,I0, 8'h00,8'hFF);
        vecs[8]  = mkVec(I0,I0,I0,I0,8'h00, I0,I0,I1, I0,I1,I1,I0, 8'h00,8'h3C);
        vecs[9]  = mkVec(I0,I0,I0,I0,8'h00, I0,I0,I1, I0,I1,I1,I0, 8'h00,8'h3C);
        vecs[10] = mkVec(I0,I0,I0,I0,8'h00, I0,I0,I1, I1,I1,I1,I0, 8'h3C,8'hFF);
        vecs[11] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I1,I1, 8'h3C,8'hFF);
        vecs[12] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h3C,8'hFF);
        vecs[13] = mkVec(I0,I1,I1,I1,8'h5A, I0,I1,I1, I1,I1,I1,I0, 8'h3C,8'h5A);
        vecs[14] = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I0,I1,I0, 8'h3C,8'h5A);
        vecs[15] = mkVec(I1,I0,I0,I0,8'h00, I1,I0,I1, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[16] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[17] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[18] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h00,8'hFF);
        vecs[19] = mkVec(I0,I1,I1,I0,8'hC3, I0,I0,I1, I1,I1,I1,I0, 8'h00,8'hC3);
        vecs[20] = mkVec(I0,I1,I1,I0,8'hC3, I0,I0,I1, I1,I0,I1,I0, 8'h00,8'hC3);
        vecs[21] = mkVec(I0,I1,I1,I0,8'hC3, I0,I0,I1, I1,I0,I1,I0, 8'h00,8'hC3);
        vecs[22] = mkVec(I0,I1,I1,I0,8'hC3, I0,I0,I1, I1,I1,I1,I0, 8'h00,8'hC3);
        vecs[23] = mkVec(I0,I1,I1,I0,8'hC3, I1,I0,I0, I1,I1,I1,I1, 8'h00,8'hFF);
        vecs[24] = mkVec(I0,I1,I1,I1,8'h96, I0,I1,I1, I1,I1,I1,I0, 8'h00,8'h96);
        vecs[25] = mkVec(I0,I1,I1,I1,8'h11, I0,I1,I1, I1,I0,I1,I0, 8'h00,8'h96);
        vecs[26] = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I0,I1,I0, 8'h00,8'h96);
        vecs[27] = mkVec(I0,I0,I0,I0,8'h00, I0,I1,I1, I1,I1,I1,I0, 8'h00,8'h96);
        vecs[28] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I1,I1, 8'h00,8'hFF);
        vecs[29] = mkVec(I0,I0,I0,I0,8'h00, I1,I0,I0, I1,I1,I0,I0, 8'h00,8'hFF);

        $display("[TB] table vectors on default-timing master");
        for (int i = 0; i < 30; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].wr, vecs[i].addr,
                          vecs[i].wdata);
            @(posedge clock);
            #1;
            checkBit($sformatf("vec%0d s_", i), ifc0.s_, vecs[i].eS);
            checkBit($sformatf("vec%0d ior_", i), ifc0.ior_, vecs[i].eIor);
            checkBit($sformatf("vec%0d iow_", i), ifc0.iow_, vecs[i].eIow);
            checkBit($sformatf("vec%0d busy", i), ifc0.busy, vecs[i].eBusy);
            checkBit($sformatf("vec%0d done", i), ifc0.done, vecs[i].eDone);
            checkOutput($sformatf("vec%0d rdata", i), ifc0.rdata, vecs[i].eRdata);
            checkOutput($sformatf("vec%0d bus", i), dBus0, vecs[i].eBus);
            if (vecs[i].chkA0) checkBit($sformatf("vec%0d a0", i), ifc0.a0, vecs[i].eA0);
        end

        // 3/4/2 read: busy for 10 cycles, ior_ low in cycles 4-7, done in
        // cycle 10
        $display("[TB] parameterised read on 3/4/2 master");
        applyStimulus(I1, I0, I0, I0, 8'h00);
        @(posedge clock);
        #1;
        sData = 8'h7E;
        applyStimulus(I0, I1, I0, I1, 8'h00);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) applyStimulus(I0, I0, I0, I0, 8'h00);
            checkBit($sformatf("par c%0d busy", k), ifc1.busy, k <= 10);
            checkBit($sformatf("par c%0d ior_", k), ifc1.ior_, !(k >= 4 && k <= 7));
            checkBit($sformatf("par c%0d iow_", k), ifc1.iow_, 1'b1);
            checkBit($sformatf("par c%0d done", k), ifc1.done, k == 10);
            checkBit($sformatf("par c%0d s_", k), ifc1.s_, !(k <= 9));
            checkOutput($sformatf("par c%0d bus", k), dBus1,
                        (k >= 4 && k <= 7) ? 8'h7E : 8'hFF);
            if (k == 10) checkOutput("par rdata", ifc1.rdata, 8'h7E);
        end

`ifdef IO_BUS_WAIT_EN
        // rdy low for 3 cycles after the strobe count expires: strobe low
        // in cycles 2-6, data sampled at the rdy=1 edge
        $display("[TB] wait-state read on default-timing master");
        applyStimulus(I1, I0, I0, I0, 8'h00);
        @(posedge clock);
        #1;
        sData = 8'h11;
        rdy0  = 1'b0;
        applyStimulus(I0, I1, I0, I0, 8'h00);
        for (int k = 1; k <= 9; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) applyStimulus(I0, I0, I0, I0, 8'h00);
            checkBit($sformatf("wait c%0d ior_", k), ifc0.ior_, !(k >= 2 && k <= 6));
            checkBit($sformatf("wait c%0d busy", k), ifc0.busy, k <= 8);
            checkBit($sformatf("wait c%0d done", k), ifc0.done, k == 8);
            checkOutput($sformatf("wait c%0d rdata", k), ifc0.rdata,
                        (k >= 7) ? 8'h99 : 8'h00);
            if (k == 5) sData = 8'h99;
            if (k == 6) rdy0 = 1'b1;
        end
`endif

        // Randomised traffic on both masters, checked every cycle against the
        // transaction model
        $display("[TB] random traffic against reference model");
        for (int cyc = 0; cyc < 400; cyc++) begin
            rRst   = (cyc == 0) || ($urandom_range(0, 59) == 0);
            rReq   = ($urandom_range(0, 9) < 5);
            rWr    = $urandom_range(0, 1) == 1;
            rAddr  = $urandom_range(0, 1) == 1;
            rWdata = 8'($urandom_range(0, 255));
            sData  = 8'($urandom_range(0, 255));
            rIn0   = 1'b1;
            rIn1   = 1'b1;
`ifdef IO_BUS_WAIT_EN
            rdy0 = ($urandom_range(0, 3) != 0);
            rdy1 = ($urandom_range(0, 3) != 0);
            rIn0 = rdy0;
            rIn1 = rdy1;
`endif
            applyStimulus(rRst, rReq, rWr, rAddr, rWdata);
            modelStep(0, rRst, rReq, rWr, rAddr, rWdata, rIn0, sData);
            modelStep(1, rRst, rReq, rWr, rAddr, rWdata, rIn1, sData);
            @(posedge clock);
            #1;
            checkModel(0, ifc0.s_, ifc0.a0, ifc0.ior_, ifc0.iow_, ifc0.busy,
                       ifc0.done, ifc0.rdata, dBus0);
            checkModel(1, ifc1.s_, ifc1.a0, ifc1.ior_, ifc1.iow_, ifc1.busy,
                       ifc1.done, ifc1.rdata, dBus1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
